// File: rtl/run_detect_arbiter_pkg.sv
// ============================================================================
// run_detect_arbiter_pkg: FSM encoding and default sizes shared by the
// run_detect_arbiter block.  Rev 1.0
// ============================================================================
`default_nettype none

package run_detect_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int WORD_W_DEF  = 8;
   localparam int RUN_LEN_DEF = 4;
   localparam int CNT_W_DEF   = 4;

endpackage

`default_nettype wire

// File: rtl/run_detect_arbiter_run_detector.sv
// ============================================================================
// run_detector: flags every bit that completes (or extends) a run of RUN_LEN
// equal bits; runs saturate at RUN_LEN.  Rev 1.0
// ============================================================================
`default_nettype none

module run_detector #(
   parameter int RUN_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   input  logic w,
   output logic hit,
   output logic z
);

   localparam int RW = $clog2(RUN_LEN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

   logic          last;
   logic          first;
   logic [RW-1:0] run;
   logic [RW-1:0] run_next;

   always_comb begin
      run_next = RW'(1);
      if (w == last && !first)
         run_next = (run == RUN_MAX) ? RUN_MAX : run + RW'(1);
      hit = en && (run_next == RUN_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         last  <= 1'b0;
         first <= 1'b1;
         run   <= '0;
         z     <= 1'b0;
      end else begin
         z <= hit;
         if (en) begin
            last  <= w;
            first <= 1'b0;
            run   <= run_next;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/run_detect_arbiter.sv
// ============================================================================
// run_detect_arbiter: round-robin shares one serial run detector between two
// word sources and returns the hit count over a valid/ready port.  Rev 1.0
// ============================================================================
`default_nettype none

module run_detect_arbiter
   import run_detect_arbiter_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int RUN_LEN = RUN_LEN_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [WORD_W-1:0] data0,
   input  logic [WORD_W-1:0] data1,
   output logic [1:0]        grant,
   output logic              busy,
   output logic              res_valid,
   output logic              res_id,
   output logic [CNT_W-1:0]  res_count,
   input  logic              res_ready
);

   localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

   state_t            state;
   state_t            next_state;
   logic              ptr;
   logic              winner;
   logic              take;
   logic              accept;
   logic [WORD_W-1:0] sr;
   logic [BC_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]  count;
   logic              hit;
   logic              z_unused;

   always_comb begin
      next_state = state;
      grant      = 2'b00;
      winner     = req[ptr] ? ptr : ~ptr;
      take       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               grant[winner] = 1'b1;
               take          = 1'b1;
               next_state    = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt == LAST_BIT)
               next_state = DONE;
         end
         DONE: begin
            if (res_ready) begin
               accept     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         sr      <= '0;
         bit_cnt <= '0;
         count   <= '0;
         res_id  <= 1'b0;
      end else begin
         state <= next_state;
         if (take) begin
            sr      <= winner ? data1 : data0;
            res_id  <= winner;
            count   <= '0;
            bit_cnt <= '0;
         end
         if (state == SHIFT) begin
            sr      <= {sr[WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BC_W'(1);
            if (hit)
               count <= count + CNT_W'(1);
         end
         // The served requester drops to lowest priority for the next round.
         if (accept)
            ptr <= ~res_id;
      end
   end

   run_detector #(
      .RUN_LEN (RUN_LEN)
   ) u_det (
      .clk   (clk),
      .reset (reset),
      .clear (take),
      .en    (state == SHIFT),
      .w     (sr[WORD_W-1]),
      .hit   (hit),
      .z     (z_unused)
   );

   assign busy      = (state != IDLE);
   assign res_valid = (state == DONE);
   assign res_count = count;

endmodule

`default_nettype wire
